// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle MIPS control unit: FSM state
// enumeration, opcode/funct values and the encodings driven onto the
// datapath select lines (pc_src, alusrcA, alusrcB, alu_op, regdest,
// memtoreg) and the fault code.
// Optional feature macro: EXT_ISA_EN (adds bne/jal and their encodings).
// ---------------------------------------------------------------------------
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXEC,
      S_ALUWB,
      S_BRANCH,
      S_JUMP,
      S_FAULT
   } state_t;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef EXT_ISA_EN
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BNE   = 6'h05;
`endif

   // Funct values (IR[5:0]) that change sequencing or operand selection
   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_JR  = 6'h08;

   // pc_src
   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
   localparam logic [1:0] PC_SRC_RS     = 2'd3;

   // alusrcA
   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_RS    = 2'd1;
   localparam logic [1:0] SRCA_SHAMT = 2'd2;

   // alusrcB
   localparam logic [1:0] SRCB_RT     = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   // alu_op
   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;

   // regdest / memtoreg (value 2 only exists with the extended ISA)
   localparam logic [1:0] RD_RT      = 2'd0;
   localparam logic [1:0] RD_RD      = 2'd1;
   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
`ifdef EXT_ISA_EN
   localparam logic [1:0] RD_RA      = 2'd2;
   localparam logic [1:0] M2R_PC     = 2'd2;
`endif

   // fault
   localparam logic [1:0] FAULT_NONE    = 2'd0;
   localparam logic [1:0] FAULT_TIMEOUT = 2'd1;
   localparam logic [1:0] FAULT_ILLEGAL = 2'd2;

   // States that wait on mem_ready and are guarded by the stall watchdog.
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// ---------------------------------------------------------------------------
// mc_wait_timer
// Stall watchdog for memory states. Counts consecutive cycles spent waiting
// on mem_ready; expired is high once WAIT_LIMIT wait cycles have elapsed,
// i.e. on the last cycle in which the access may still complete.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clr         - clear the count (outside memory states or on mem_ready)
//   waiting     - a memory state is waiting this cycle
//   expired     - count has reached WAIT_LIMIT
// ---------------------------------------------------------------------------
module mc_wait_timer #(
   parameter int WAIT_LIMIT = 15,
   parameter int WAIT_W     = $clog2(WAIT_LIMIT + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic waiting,
   output logic expired
);

   logic [WAIT_W-1:0] count;

   // NOTE: sequential state is always updated with non-blocking assignments
   // so every register samples pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (waiting && !expired) begin
         count <= count + WAIT_W'(1);
      end
   end

   assign expired = (count == WAIT_W'(WAIT_LIMIT));

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Multicycle MIPS control FSM. Sequences each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath selects and
// enables each cycle. Memory states wait on mem_ready under a stall
// watchdog; timeouts and illegal opcodes park the FSM in FAULT with a
// sticky fault code until reset.
// Optional feature macro: EXT_ISA_EN (adds bne 0x05 and jal 0x03).
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   opcode, funct        - IR[31:26], IR[5:0] (held stable by the IR)
//   zero                 - ALU zero flag, used in BRANCH
//   mem_ready            - memory completes the current access
//   pc_write, pc_src     - PC load enable / source select
//   ir_write, iord       - IR load enable / memory address select
//   mem_read, mem_write  - memory strobes
//   reg_write, regdest   - register file write enable / destination select
//   memtoreg             - register write data select
//   alusrcA, alusrcB     - ALU operand selects
//   alu_op               - add / sub / use funct
//   instr_done           - pulse on final cycle of each instruction
//   fault                - 0 none, 1 memory timeout, 2 illegal instruction
// ---------------------------------------------------------------------------
module multicycle_control
   import mc_pkg::*;
#(
   parameter int WAIT_LIMIT = 15,
   parameter int WAIT_W     = $clog2(WAIT_LIMIT + 1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       ir_write,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] regdest,
   output logic [1:0] memtoreg,
   output logic [1:0] alusrcA,
   output logic [1:0] alusrcB,
   output logic [1:0] alu_op,
   output logic       instr_done,
   output logic [1:0] fault
);

   state_t     state, next_state;
   logic [1:0] fault_q, fault_next;
   logic       in_mem, expired, timeout;

   assign in_mem = is_mem_state(state);

   mc_wait_timer #(
      .WAIT_LIMIT (WAIT_LIMIT),
      .WAIT_W     (WAIT_W)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (!in_mem || mem_ready),
      .waiting (in_mem && !mem_ready),
      .expired (expired)
   );

   // mem_ready on the limit cycle completes the access instead of faulting.
   assign timeout = expired && !mem_ready;
   assign fault   = fault_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_FETCH;
         fault_q <= FAULT_NONE;
      end else begin
         state   <= next_state;
         fault_q <= fault_next;
      end
   end

   always_comb begin
      // NOTE: every output and next-state variable gets a default before the
      // case so no path leaves one unassigned, which would infer a latch.
      next_state = state;
      fault_next = fault_q;
      pc_write   = 1'b0;
      pc_src     = PC_SRC_ALU;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      regdest    = RD_RT;
      memtoreg   = M2R_ALUOUT;
      alusrcA    = SRCA_PC;
      alusrcB    = SRCB_RT;
      alu_op     = ALU_ADD;
      instr_done = 1'b0;

      case (state)
         S_FETCH: begin
            mem_read = 1'b1;
            alusrcA  = SRCA_PC;
            alusrcB  = SRCB_FOUR;
            alu_op   = ALU_ADD;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               pc_src     = PC_SRC_ALU;
               next_state = S_DECODE;
            end else if (timeout) begin
               next_state = S_FAULT;
               fault_next = FAULT_TIMEOUT;
            end
         end

         S_DECODE: begin
            // Branch target is computed speculatively into ALUOut.
            alusrcA = SRCA_PC;
            alusrcB = SRCB_IMM_SH;
            alu_op  = ALU_ADD;
            case (opcode)
               OP_LW, OP_SW:      next_state = S_MEMADR;
               OP_RTYPE:          next_state = (funct == FN_JR) ? S_JUMP : S_EXEC;
               OP_ADDI, OP_ADDIU: next_state = S_EXEC;
               OP_BEQ:            next_state = S_BRANCH;
               OP_J:              next_state = S_JUMP;
`ifdef EXT_ISA_EN
               OP_BNE:            next_state = S_BRANCH;
               OP_JAL:            next_state = S_JUMP;
`endif
               default: begin
                  next_state = S_FAULT;
                  fault_next = FAULT_ILLEGAL;
               end
            endcase
         end

         S_MEMADR: begin
            alusrcA    = SRCA_RS;
            alusrcB    = SRCB_IMM;
            alu_op     = ALU_ADD;
            next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end

         S_MEMRD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
            if (mem_ready) begin
               next_state = S_MEMWB;
            end else if (timeout) begin
               next_state = S_FAULT;
               fault_next = FAULT_TIMEOUT;
            end
         end

         S_MEMWB: begin
            reg_write  = 1'b1;
            regdest    = RD_RT;
            memtoreg   = M2R_MDR;
            instr_done = 1'b1;
            next_state = S_FETCH;
         end

         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               next_state = S_FETCH;
            end else if (timeout) begin
               next_state = S_FAULT;
               fault_next = FAULT_TIMEOUT;
            end
         end

         S_EXEC: begin
            if (opcode == OP_RTYPE) begin
               alusrcA = ((funct == FN_SLL) || (funct == FN_SRL)) ? SRCA_SHAMT : SRCA_RS;
               alusrcB = SRCB_RT;
               alu_op  = ALU_FUNCT;
            end else begin
               alusrcA = SRCA_RS;
               alusrcB = SRCB_IMM;
               alu_op  = ALU_ADD;
            end
            next_state = S_ALUWB;
         end

         S_ALUWB: begin
            reg_write  = 1'b1;
            memtoreg   = M2R_ALUOUT;
            regdest    = (opcode == OP_RTYPE) ? RD_RD : RD_RT;
            instr_done = 1'b1;
            next_state = S_FETCH;
         end

         S_BRANCH: begin
            alusrcA  = SRCA_RS;
            alusrcB  = SRCB_RT;
            alu_op   = ALU_SUB;
            pc_src   = PC_SRC_ALUOUT;
            pc_write = zero;
`ifdef EXT_ISA_EN
            if (opcode == OP_BNE) pc_write = !zero;
`endif
            instr_done = 1'b1;
            next_state = S_FETCH;
         end

         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = (opcode == OP_RTYPE) ? PC_SRC_RS : PC_SRC_JUMP;
`ifdef EXT_ISA_EN
            if (opcode == OP_JAL) begin
               reg_write = 1'b1;
               regdest   = RD_RA;
               memtoreg  = M2R_PC;
            end
`endif
            instr_done = 1'b1;
            next_state = S_FETCH;
         end

         S_FAULT: begin
            next_state = S_FAULT;
         end

         default: begin
            next_state = S_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Self-checking bench for multicycle_control (built with WAIT_LIMIT=4).
// A directed table checks latency and writeback/PC controls per instruction;
// a per-instruction reference model expands each instruction into its
// expected per-cycle outputs, including memory waits and faults.
// Optional feature macro: EXT_ISA_EN (expectations follow the build).
// ---------------------------------------------------------------------------
module tb_multicycle_control;

   localparam int LIM = 4;
`ifdef EXT_ISA_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, zero, mem_ready;
   logic [5:0] opcode, funct;
   logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write, instr_done;
   logic [1:0] pc_src, regdest, memtoreg, alusrcA, alusrcB, alu_op, fault;

   multicycle_control #(.WAIT_LIMIT(LIM)) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .ir_write   (ir_write),
      .iord       (iord),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .reg_write  (reg_write),
      .regdest    (regdest),
      .memtoreg   (memtoreg),
      .alusrcA    (alusrcA),
      .alusrcB    (alusrcB),
      .alu_op     (alu_op),
      .instr_done (instr_done),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_src;
      logic       ir_write, iord, mem_read, mem_write, reg_write;
      logic [1:0] regdest, memtoreg, alusrc_a, alusrc_b, alu_op;
      logic       instr_done;
      logic [1:0] fault;
   } out_t;

   typedef struct {
      logic mem_ready;
      logic zero;
      out_t exp;
   } step_t;

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      int         cycles;
      logic [7:0] wb;   // {reg_write, regdest, memtoreg, pc_write, pc_src} on the done cycle
   } vec_t;

   out_t  act;
   step_t steps[$];
   vec_t  vecs[$];
   int    vectors = 0;
   int    miscompares = 0;

   assign act = {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
                 regdest, memtoreg, alusrcA, alusrcB, alu_op, instr_done, fault};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic out_t fetch_out(input logic rdy);
      out_t o = '0;
      o.mem_read = 1'b1;
      o.alusrc_b = 2'd1;
      if (rdy) begin
         o.ir_write = 1'b1;
         o.pc_write = 1'b1;
      end
      return o;
   endfunction

   task automatic push(input out_t o, input logic rdy, input logic z);
      step_t s;
      s.mem_ready = rdy;
      s.zero      = z;
      s.exp       = o;
      steps.push_back(s);
   endtask

   // Cycle whose outputs do not depend on mem_ready or zero: drive noise.
   task automatic push_free(input out_t o);
      push(o, rnd(), rnd());
   endtask

   task automatic push_fault(input logic [1:0] code, input int n);
      out_t o = '0;
      o.fault = code;
      repeat (n) push_free(o);
   endtask

   // A memory access that waits w cycles; w beyond LIM means a timeout.
   task automatic push_mem(input out_t busy, input out_t done, input int w, output bit faulted);
      faulted = (w > LIM);
      for (int i = 0; i < (faulted ? LIM + 1 : w); i++) push(busy, 1'b0, rnd());
      if (faulted) push_fault(2'd1, 3);
      else         push(done, 1'b1, rnd());
   endtask

   // Reference model: expected cycle-by-cycle outputs of one instruction.
   task automatic model_instr(input logic [5:0] op, input logic [5:0] fn,
                              input int w_fetch, input int w_mem, output bit faulted);
      out_t o, r;
      logic z;
      bit   is_r, is_mem, is_jal, is_bne, is_jump, is_alu, is_br;
      is_r    = (op == 6'h00);
      is_mem  = (op == 6'h23) || (op == 6'h2B);
      is_jal  = EXT && (op == 6'h03);
      is_bne  = EXT && (op == 6'h05);
      is_jump = (is_r && fn == 6'h08) || (op == 6'h02) || is_jal;
      is_alu  = (is_r && fn != 6'h08) || (op == 6'h08) || (op == 6'h09);
      is_br   = (op == 6'h04) || is_bne;

      push_mem(fetch_out(1'b0), fetch_out(1'b1), w_fetch, faulted);
      if (faulted) return;
      o = '0; o.alusrc_b = 2'd3;
      push_free(o);

      if (is_mem) begin
         o = '0; o.alusrc_a = 2'd1; o.alusrc_b = 2'd2;
         push_free(o);
         o = '0; o.iord = 1'b1;
         if (op == 6'h23) begin
            o.mem_read = 1'b1;
            push_mem(o, o, w_mem, faulted);
            if (faulted) return;
            o = '0; o.reg_write = 1'b1; o.memtoreg = 2'd1; o.instr_done = 1'b1;
            push_free(o);
         end else begin
            o.mem_write = 1'b1;
            r = o; r.instr_done = 1'b1;
            push_mem(o, r, w_mem, faulted);
         end
      end else if (is_alu) begin
         o = '0;
         if (is_r) begin
            o.alusrc_a = (fn == 6'h00 || fn == 6'h02) ? 2'd2 : 2'd1;
            o.alu_op   = 2'd2;
         end else begin
            o.alusrc_a = 2'd1;
            o.alusrc_b = 2'd2;
         end
         push_free(o);
         o = '0; o.reg_write = 1'b1; o.regdest = is_r ? 2'd1 : 2'd0; o.instr_done = 1'b1;
         push_free(o);
      end else if (is_br) begin
         z = rnd();
         o = '0; o.alusrc_a = 2'd1; o.alu_op = 2'd1; o.pc_src = 2'd1;
         o.pc_write = is_bne ? !z : z;
         o.instr_done = 1'b1;
         push(o, rnd(), z);
      end else if (is_jump) begin
         o = '0; o.pc_write = 1'b1; o.pc_src = is_r ? 2'd3 : 2'd2; o.instr_done = 1'b1;
         if (is_jal) begin
            o.reg_write = 1'b1; o.regdest = 2'd2; o.memtoreg = 2'd2;
         end
         push_free(o);
      end else begin
         push_fault(2'd2, 3);
         faulted = 1'b1;
      end
   endtask

   // Apply queued cycles; done_at is the first cycle the DUT raised instr_done.
   task automatic play(input string name, output int done_at);
      step_t s;
      int    cyc = 0;
      done_at = -1;
      while (steps.size() > 0) begin
         s = steps.pop_front();
         cyc++;
         mem_ready = s.mem_ready;
         zero      = s.zero;
         @(negedge clk);
         if (instr_done && done_at < 0) done_at = cyc;
         check($sformatf("%s cycle %0d", name, cyc), 32'(act), 32'(s.exp));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   out_t       o;
   int         d, cyc;
   bit         flt, seen;
   logic [5:0] illegal_op;
   logic [11:0] legal[$];
   logic [11:0] pick;

   initial begin
      reset = 1'b1; zero = 1'b0; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h20;

      vecs.push_back('{"add",   6'h00, 6'h20, 1'b0, 4, {1'b1, 2'd1, 2'd0, 1'b0, 2'd0}});
      vecs.push_back('{"sll",   6'h00, 6'h00, 1'b0, 4, {1'b1, 2'd1, 2'd0, 1'b0, 2'd0}});
      vecs.push_back('{"sub",   6'h00, 6'h22, 1'b1, 4, {1'b1, 2'd1, 2'd0, 1'b0, 2'd0}});
      vecs.push_back('{"addi",  6'h08, 6'h15, 1'b0, 4, {1'b1, 2'd0, 2'd0, 1'b0, 2'd0}});
      vecs.push_back('{"addiu", 6'h09, 6'h08, 1'b0, 4, {1'b1, 2'd0, 2'd0, 1'b0, 2'd0}});
      vecs.push_back('{"lw",    6'h23, 6'h00, 1'b0, 5, {1'b1, 2'd0, 2'd1, 1'b0, 2'd0}});
      vecs.push_back('{"sw",    6'h2B, 6'h00, 1'b1, 4, {1'b0, 2'd0, 2'd0, 1'b0, 2'd0}});
      vecs.push_back('{"beq z1", 6'h04, 6'h00, 1'b1, 3, {1'b0, 2'd0, 2'd0, 1'b1, 2'd1}});
      vecs.push_back('{"beq z0", 6'h04, 6'h00, 1'b0, 3, {1'b0, 2'd0, 2'd0, 1'b0, 2'd1}});
      vecs.push_back('{"j",     6'h02, 6'h00, 1'b0, 3, {1'b0, 2'd0, 2'd0, 1'b1, 2'd2}});
      vecs.push_back('{"jr",    6'h00, 6'h08, 1'b0, 3, {1'b0, 2'd0, 2'd0, 1'b1, 2'd3}});
`ifdef EXT_ISA_EN
      vecs.push_back('{"bne z0", 6'h05, 6'h00, 1'b0, 3, {1'b0, 2'd0, 2'd0, 1'b1, 2'd1}});
      vecs.push_back('{"bne z1", 6'h05, 6'h00, 1'b1, 3, {1'b0, 2'd0, 2'd0, 1'b0, 2'd1}});
      vecs.push_back('{"jal",   6'h03, 6'h00, 1'b0, 3, {1'b1, 2'd2, 2'd2, 1'b1, 2'd2}});
`endif

      // Reset state: FETCH decode values, no fault.
      do_reset();
      @(negedge clk);
      check("reset outputs", 32'(act), 32'(fetch_out(1'b0)));
      @(posedge clk);
      #1;

      // Directed table with mem_ready held high.
      foreach (vecs[i]) begin
         opcode = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z; mem_ready = 1'b1;
         cyc = 0; seen = 1'b0;
         while (!seen && cyc < 20) begin
            cyc++;
            @(negedge clk);
            if (instr_done) begin
               seen = 1'b1;
               check({vecs[i].name, " done-cycle controls"},
                     32'({reg_write, regdest, memtoreg, pc_write, pc_src}), 32'(vecs[i].wb));
            end
            @(posedge clk);
            #1;
         end
         check({vecs[i].name, " latency"}, cyc, vecs[i].cycles);
         if (!seen) do_reset();
      end

      // lw with three wait cycles in MEMRD completes on cycle 8.
      do_reset();
      opcode = 6'h23; funct = 6'h00;
      model_instr(opcode, funct, 0, 3, flt);
      play("lw 3 waits", d);
      check("lw 3 waits done cycle", d, 8);

      // sw with exactly LIM waits in FETCH and MEMWR: ready on the limit cycle wins.
      opcode = 6'h2B;
      model_instr(opcode, funct, LIM, LIM, flt);
      play("sw limit waits", d);
      check("sw limit waits done cycle", d, 4 + 2 * LIM);

      // FETCH timeout: fault=1 and all enables low until reset.
      opcode = 6'h00; funct = 6'h20;
      model_instr(opcode, funct, LIM + 1, 0, flt);
      push_fault(2'd1, 4);
      play("fetch timeout", d);
      do_reset();
      @(negedge clk);
      check("reset after timeout", 32'(act), 32'(fetch_out(1'b0)));
      @(posedge clk);
      #1;

      // MEMRD timeout.
      opcode = 6'h23;
      model_instr(opcode, funct, 0, LIM + 1, flt);
      play("memrd timeout", d);
      do_reset();

      // Opcode 0x05: illegal in the base ISA, bne with the extension.
      opcode = 6'h05; funct = 6'h00;
      model_instr(opcode, funct, 0, 0, flt);
      play("opcode 05", d);
      do_reset();
      illegal_op = 6'h3F;
      opcode = illegal_op;
      model_instr(opcode, funct, 1, 0, flt);
      play("opcode 3f", d);
      do_reset();

      // Reset asserted while MEMWR waits.
      opcode = 6'h2B;
      push(fetch_out(1'b1), 1'b1, 1'b0);
      o = '0; o.alusrc_b = 2'd3; push_free(o);
      o = '0; o.alusrc_a = 2'd1; o.alusrc_b = 2'd2; push_free(o);
      play("sw before reset", d);
      mem_ready = 1'b0; reset = 1'b1;
      @(negedge clk);
      check("memwr before reset edge", 32'(mem_write), 32'(1));
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset during memwr", 32'(act), 32'(fetch_out(1'b0)));
      @(posedge clk);
      #1;

      // Randomized legal instruction stream with random memory latency.
      legal = '{12'h020, 12'h022, 12'h000, 12'h002, 12'h02A, 12'h008,
                12'h200, 12'h240, 12'h8C0, 12'hAC0, 12'h100, 12'h080};
      if (EXT) begin
         legal.push_back(12'h140);
         legal.push_back(12'h0C0);
      end
      do_reset();
      for (int n = 0; n < 60; n++) begin
         pick   = legal[$urandom_range(0, legal.size() - 1)];
         opcode = pick[11:6];
         funct  = (pick[11:6] == 6'h00) ? pick[5:0] : 6'($urandom);
         model_instr(opcode, funct, $urandom_range(0, LIM), $urandom_range(0, LIM), flt);
         play($sformatf("random #%0d op %02h", n, opcode), d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
